timer_counter: RTL and testbench

- Memory-mapped timer/counter peripheral on the CPU bridge bus: the CPU's bus address, write data, byte-enable and read-data lines connect to it, and it produces one of the HWInt[7:2] lines.
- Provides a 32-bit down-counter with a software preset, a one-shot mode and a periodic auto-reload mode, and a maskable interrupt request.

---
 rtl/timer_counter.sv | 116 +++++++++++
 tb/tb_timer_counter.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/timer_counter.sv
// Memory-mapped 32-bit down-counter with software preset, one-shot and
// periodic auto-reload modes, and a maskable interrupt request.
module timer_counter (
   input  logic        clk,
   input  logic        reset,
   input  logic [1:0]  Addr,
   input  logic [3:0]  WE,
   input  logic [31:0] Din,
   output logic [31:0] Dout,
   output logic        IRQ
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LOAD = 2'd1,
      S_CNT  = 2'd2,
      S_INT  = 2'd3
   } state_t;

   localparam logic [1:0] ADDR_CTRL   = 2'd0;
   localparam logic [1:0] ADDR_PRESET = 2'd1;
   localparam logic [1:0] ADDR_COUNT  = 2'd2;

   state_t      state_q, state_d;
   logic [3:0]  ctrl_q, ctrl_d;
   logic [31:0] preset_q, preset_d;
   logic [31:0] count_q, count_d;
   logic        flag_q, flag_d;

   logic ctrl_en;
   logic ctrl_periodic;
   logic wr_any;
   logic wr_ctrl;
   logic wr_preset;

   assign ctrl_en       = ctrl_q[0];
   assign ctrl_periodic = (ctrl_q[2:1] == 2'b01);
   assign wr_any        = |WE;
   assign wr_ctrl       = wr_any && (Addr == ADDR_CTRL);
   assign wr_preset     = wr_any && (Addr == ADDR_PRESET);

   always_comb begin
      state_d  = state_q;
      ctrl_d   = ctrl_q;
      preset_d = preset_q;
      count_d  = count_q;
      flag_d   = flag_q;

      case (state_q)
         S_IDLE: begin
            if (ctrl_en) state_d = S_LOAD;
         end
         S_LOAD: begin
            count_d = preset_q;
            state_d = S_CNT;
         end
         S_CNT: begin
            if (!ctrl_en) begin
               state_d = S_IDLE;
            end else if (count_q == 32'd0) begin
               state_d = S_INT;
               flag_d  = 1'b1;
            end else begin
               count_d = count_q - 32'd1;
            end
         end
         S_INT: begin
            if (ctrl_periodic) begin
               state_d = S_LOAD;
               flag_d  = 1'b0;
            end else begin
               ctrl_d[0] = 1'b0;
               state_d   = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase

      // Software writes are applied last so they win over the FSM's EN clear.
      if (wr_ctrl && WE[0]) ctrl_d = Din[3:0];
      if (wr_preset) begin
         for (int i = 0; i < 4; i++) begin
            if (WE[i]) preset_d[8*i +: 8] = Din[8*i +: 8];
         end
      end
      if (wr_ctrl || wr_preset) flag_d = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= S_IDLE;
         ctrl_q   <= 4'd0;
         preset_q <= 32'd0;
         count_q  <= 32'd0;
         flag_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         ctrl_q   <= ctrl_d;
         preset_q <= preset_d;
         count_q  <= count_d;
         flag_q   <= flag_d;
      end
   end

   always_comb begin
      case (Addr)
         ADDR_CTRL:   Dout = {28'd0, ctrl_q};
         ADDR_PRESET: Dout = preset_q;
         ADDR_COUNT:  Dout = count_q;
         default:     Dout = 32'd0;
      endcase
   end

   assign IRQ = flag_q & ctrl_q[3];

endmodule

// File: tb/tb_timer_counter.sv
// Directed bench for timer_counter: a register-access vector table followed
// by hand-timed sequences for counting, interrupts and corner cases.
module tb_timer_counter;

   logic        clk;
   logic        reset;
   logic [1:0]  Addr;
   logic [3:0]  WE;
   logic [31:0] Din;
   logic [31:0] Dout;
   logic        IRQ;

   int checks = 0;
   int errors = 0;

   timer_counter dut (
      .clk   (clk),
      .reset (reset),
      .Addr  (Addr),
      .WE    (WE),
      .Din   (Din),
      .Dout  (Dout),
      .IRQ   (IRQ)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]  addr;
      logic [3:0]  we;
      logic [31:0] din;
      logic [1:0]  rd_addr;
      logic [31:0] exp_dout;
   } vec_t;

   vec_t vecs[14];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Returns 1 ns after the rising edge at which the write lands.
   task automatic wr(input logic [1:0] a, input logic [31:0] d, input logic [3:0] we);
      Addr = a;
      Din  = d;
      WE   = we;
      @(posedge clk);
      #1;
      WE   = 4'h0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic rd(input string name, input logic [1:0] a, input logic [31:0] exp);
      Addr = a;
      #1;
      check(name, Dout, exp);
   endtask

   task automatic chk_irq(input string name, input logic exp);
      check(name, {31'd0, IRQ}, {31'd0, exp});
   endtask

   task automatic chk_state(input string name, input logic [1:0] exp);
      logic [1:0] s;
      s = dut.state_q;
      check(name, {30'd0, s}, {30'd0, exp});
   endtask

   initial begin
      vecs[0]  = '{2'd0, 4'h0, 32'h0,        2'd0, 32'h0};
      vecs[1]  = '{2'd0, 4'h0, 32'h0,        2'd1, 32'h0};
      vecs[2]  = '{2'd0, 4'h0, 32'h0,        2'd2, 32'h0};
      vecs[3]  = '{2'd0, 4'h0, 32'h0,        2'd3, 32'h0};
      vecs[4]  = '{2'd0, 4'hF, 32'hFFFFFFFF, 2'd0, 32'h0000000F};
      vecs[5]  = '{2'd0, 4'hF, 32'h0,        2'd0, 32'h0};
      vecs[6]  = '{2'd1, 4'hF, 32'h11223344, 2'd1, 32'h11223344};
      vecs[7]  = '{2'd1, 4'h5, 32'hAABBCCDD, 2'd1, 32'h11BB33DD};
      vecs[8]  = '{2'd2, 4'hF, 32'hFFFFFFFF, 2'd2, 32'h0};
      vecs[9]  = '{2'd3, 4'hF, 32'hFFFFFFFF, 2'd3, 32'h0};
      vecs[10] = '{2'd0, 4'hE, 32'h0000000F, 2'd0, 32'h0};
      vecs[11] = '{2'd1, 4'h8, 32'h55000000, 2'd1, 32'h55BB33DD};
      vecs[12] = '{2'd0, 4'h1, 32'h000000F6, 2'd0, 32'h00000006};
      vecs[13] = '{2'd0, 4'hF, 32'h0,        2'd0, 32'h0};

      reset = 1'b1;
      Addr  = 2'd0;
      WE    = 4'h0;
      Din   = 32'h0;
      idle(2);
      reset = 1'b0;
      chk_irq("reset_irq", 1'b0);
      chk_state("reset_state", 2'd0);

      for (int i = 0; i < 14; i++) begin
         wr(vecs[i].addr, vecs[i].din, vecs[i].we);
         rd($sformatf("vec%0d_dout", i), vecs[i].rd_addr, vecs[i].exp_dout);
         chk_irq($sformatf("vec%0d_irq", i), 1'b0);
      end
      idle(4);

      // One-shot, PRESET=5: COUNT=5 after t2, 0 after t7, IRQ after t8.
      wr(2'd1, 32'd5, 4'hF);
      wr(2'd0, 32'h9, 4'hF);
      idle(2);
      rd("os_count_t2", 2'd2, 32'd5);
      chk_irq("os_irq_t2", 1'b0);
      idle(5);
      rd("os_count_t7", 2'd2, 32'd0);
      chk_irq("os_irq_t7", 1'b0);
      idle(1);
      chk_irq("os_irq_t8", 1'b1);
      idle(1);
      rd("os_ctrl_t9", 2'd0, 32'h8);
      chk_irq("os_irq_t9", 1'b1);
      idle(3);
      chk_irq("os_irq_held", 1'b1);
      rd("os_count_held", 2'd2, 32'd0);
      chk_state("os_state_idle", 2'd0);
      wr(2'd0, 32'h8, 4'hF);
      chk_irq("os_irq_cleared", 1'b0);

      // Periodic, PRESET=3: CNT 3,2,1,0, INT (0), LOAD (0), then reload.
      wr(2'd1, 32'd3, 4'hF);
      wr(2'd0, 32'hB, 4'hF);
      idle(2);
      for (int k = 0; k < 24; k++) begin
         int p;
         logic [31:0] exp_cnt;
         p = k % 6;
         exp_cnt = (p < 4) ? 32'(3 - p) : 32'd0;
         rd($sformatf("per_count_%0d", k), 2'd2, exp_cnt);
         chk_irq($sformatf("per_irq_%0d", k), p == 4);
         idle(1);
      end
      wr(2'd0, 32'h0, 4'hF);
      idle(4);
      chk_state("per_stop_state", 2'd0);

      // Pause: EN clear lands on the edge that makes COUNT=7, so it freezes there.
      wr(2'd1, 32'd10, 4'hF);
      wr(2'd0, 32'h1, 4'hF);
      idle(4);
      rd("pause_count_t4", 2'd2, 32'd8);
      wr(2'd0, 32'h0, 4'hF);
      rd("pause_count_t5", 2'd2, 32'd7);
      idle(1);
      rd("pause_count_frozen", 2'd2, 32'd7);
      chk_state("pause_state_idle", 2'd0);
      wr(2'd2, 32'hFFFFFFFF, 4'hF);
      rd("count_readonly", 2'd2, 32'd7);
      idle(2);
      rd("pause_count_still", 2'd2, 32'd7);
      wr(2'd0, 32'h1, 4'hF);
      idle(2);
      rd("resume_reload", 2'd2, 32'd10);
      wr(2'd0, 32'h0, 4'hF);
      idle(3);

      // PRESET=0 one-shot: IRQ after t3; setting EN again restarts.
      wr(2'd1, 32'd0, 4'hF);
      wr(2'd0, 32'h9, 4'hF);
      idle(2);
      chk_irq("p0_irq_t2", 1'b0);
      idle(1);
      chk_irq("p0_irq_t3", 1'b1);
      idle(1);
      rd("p0_ctrl_t4", 2'd0, 32'h8);
      wr(2'd0, 32'h9, 4'hF);
      chk_irq("p0_restart_clr", 1'b0);
      idle(1);
      chk_state("p0_restart_load", 2'd1);
      idle(2);
      chk_irq("p0_restart_irq", 1'b1);
      wr(2'd0, 32'h0, 4'hF);
      chk_irq("p0_stop_irq", 1'b0);
      idle(3);

      // CTRL write on the INT cycle: written value wins and the flag clears.
      wr(2'd1, 32'd2, 4'hF);
      wr(2'd0, 32'h9, 4'hF);
      idle(5);
      chk_irq("col_irq_int", 1'b1);
      chk_state("col_state_int", 2'd3);
      wr(2'd0, 32'hD, 4'hF);
      rd("col_ctrl", 2'd0, 32'hD);
      chk_irq("col_irq", 1'b0);
      chk_state("col_state", 2'd0);
      wr(2'd0, 32'h0, 4'hF);
      idle(4);

      // Reset mid-count with a concurrent write.
      wr(2'd1, 32'd200, 4'hF);
      wr(2'd0, 32'h9, 4'hF);
      idle(102);
      rd("rst_count_100", 2'd2, 32'd100);
      reset = 1'b1;
      Addr  = 2'd1;
      Din   = 32'h12345678;
      WE    = 4'hF;
      @(posedge clk);
      #1;
      reset = 1'b0;
      WE    = 4'h0;
      rd("rst_ctrl", 2'd0, 32'h0);
      rd("rst_preset", 2'd1, 32'h0);
      rd("rst_count", 2'd2, 32'h0);
      chk_irq("rst_irq", 1'b0);
      chk_state("rst_state", 2'd0);
      idle(3);
      rd("rst_count_after", 2'd2, 32'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
